// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier controller for MUL/MULH/MULHSU/MULHU.
// Stalls the pipeline for XLEN+2 cycles and emits the selected product half with a done pulse.
module mul_sequencer #(
  parameter int         XLEN     = 32,
  parameter logic [4:0] MUL_C    = 5'b01010,
  parameter logic [4:0] MULH_C   = 5'b01011,
  parameter logic [4:0] MULHSU_C = 5'b01100,
  parameter logic [4:0] MULHU_C  = 5'b01101
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [4:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  // state | meaning
  // IDLE  | waiting for a multiply-class instruction in EX
  // RUN   | one shift-add iteration per cycle, XLEN cycles
  // FIX   | apply sign to the accumulator, capture result
  // DONE  | result_o/rd_o valid, pipeline released
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t              r_state, w_next;
  logic [2*XLEN-1:0]   r_mcand, r_acc;
  logic [XLEN-1:0]     r_mplier;
  logic [CW-1:0]       r_count;
  logic                r_neg, r_low;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd_o;

  logic                w_is_mul, w_accept, w_a_signed, w_b_signed, w_sign_a, w_sign_b;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic [2*XLEN-1:0]   w_fixed;

  assign w_is_mul   = (alu_ctrl_i == MUL_C) || (alu_ctrl_i == MULH_C) ||
                      (alu_ctrl_i == MULHSU_C) || (alu_ctrl_i == MULHU_C);
  // rst_n gating keeps stall_o low while reset is held with a multiply still in EX
  assign w_accept   = rst_n && (r_state == S_IDLE) && start_i && w_is_mul && !flush_i;
  assign w_a_signed = (alu_ctrl_i == MUL_C) || (alu_ctrl_i == MULH_C) || (alu_ctrl_i == MULHSU_C);
  assign w_b_signed = (alu_ctrl_i == MUL_C) || (alu_ctrl_i == MULH_C);
  assign w_sign_a   = w_a_signed && src_a_i[XLEN-1];
  assign w_sign_b   = w_b_signed && src_b_i[XLEN-1];
  assign w_mag_a    = w_sign_a ? -src_a_i : src_a_i;
  assign w_mag_b    = w_sign_b ? -src_b_i : src_b_i;
  assign w_fixed    = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (flush_i)              w_next = S_IDLE;
        else if (r_count == LAST) w_next = S_FIX;
      end
      S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o = w_accept || (r_state == S_RUN) || (r_state == S_FIX);
    busy_o  = (r_state != S_IDLE);
    done_o  = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_low    <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_o   <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= w_sign_a ^ w_sign_b;
      r_low    <= (alu_ctrl_i == MUL_C);
      r_rd     <= rd_i;
    end else if (r_state == S_RUN && !flush_i) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end else if (r_state == S_FIX && !flush_i) begin
      r_result <= r_low ? w_fixed[XLEN-1:0] : w_fixed[2*XLEN-1:XLEN];
      r_rd_o   <= r_rd;
    end
  end

  assign result_o = r_result;
  assign rd_o     = r_rd_o;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer: latency, signedness, flush, back-to-back, reset.
module tb_mul_sequencer;

  localparam logic [4:0] MUL_C    = 5'b01010;
  localparam logic [4:0] MULH_C   = 5'b01011;
  localparam logic [4:0] MULHSU_C = 5'b01100;
  localparam logic [4:0] MULHU_C  = 5'b01101;
  localparam logic [4:0] ADD_C    = 5'b00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [4:0]  alu_ctrl_i;
  logic [31:0] src_a_i, src_b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .alu_ctrl_i(alu_ctrl_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a multiply at the next negedge, holds it while stalled, checks the done cycle.
  task automatic do_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string tag,
                        output int done_cyc);
    int  n_stall;
    bit  got;
    n_stall = 0;
    got = 0;
    done_cyc = -1;
    @(negedge clk);
    start_i = 1'b1; alu_ctrl_i = op; src_a_i = a; src_b_i = b; rd_i = rd; flush_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done_o === 1'b1) begin got = 1; break; end
      if (stall_o === 1'b1) n_stall++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      done_cyc = cyc;
      chk({tag, "_stall_cycles"}, n_stall, 32'd34);
      chk({tag, "_stall_in_done"}, {31'd0, stall_o}, 32'd0);
      chk({tag, "_result"}, result_o, exp);
      chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    start_i = 1'b0; alu_ctrl_i = ADD_C; flush_i = 1'b0;
  endtask

  initial begin
    int d1, d2, d3, ndone;
    rst_n = 1'b0; start_i = 1'b0; alu_ctrl_i = ADD_C; src_a_i = '0; src_b_i = '0;
    rd_i = '0; flush_i = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_mul(MUL_C, 32'd7, 32'd6, 5'd5, 32'd42, "mul_7x6", d1);
    go_idle();
    #1;
    chk("post_done_busy", {31'd0, busy_o}, 32'd0);
    chk("post_done_done", {31'd0, done_o}, 32'd0);

    do_mul(MULH_C,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, "mulh_m1", d1);
    do_mul(MUL_C,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001, "mul_m1", d1);
    do_mul(MULH_C,   32'h80000000, 32'h80000000, 5'd3, 32'h40000000, "mulh_min", d1);
    do_mul(MULHU_C,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, "mulhu_max", d1);
    do_mul(MULHSU_C, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF, "mulhsu_m1", d1);
    do_mul(MULHSU_C, 32'h00000002, 32'h80000000, 5'd7, 32'h00000001, "mulhsu_2", d1);
    do_mul(MUL_C,    32'hFFFFFFFD, 32'd5,        5'd8, 32'hFFFFFFF1, "mul_neg", d1);
    do_mul(MULH_C,   32'hFFFFFFFD, 32'd5,        5'd9, 32'hFFFFFFFF, "mulh_neg", d1);
    go_idle();

    // flush mid-RUN: result must keep 0xFFFFFFFF, no done
    @(negedge clk);
    start_i = 1'b1; alu_ctrl_i = MUL_C; src_a_i = 32'd9; src_b_i = 32'd9; rd_i = 5'd10;
    repeat (15) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_busy_before", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0; alu_ctrl_i = ADD_C;
    #1;
    chk("flush_idle", {31'd0, busy_o}, 32'd0);
    chk("flush_result_kept", result_o, 32'hFFFFFFFF);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      if (done_o === 1'b1) ndone++;
    end
    chk("flush_no_done", ndone, 32'd0);

    // flush with start in IDLE
    @(negedge clk);
    start_i = 1'b1; alu_ctrl_i = MUL_C; flush_i = 1'b1;
    #1;
    chk("flush_start_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush_start_busy", {31'd0, busy_o}, 32'd0);

    // non-multiply code
    @(negedge clk);
    start_i = 1'b1; alu_ctrl_i = ADD_C; src_a_i = 32'd1; src_b_i = 32'd2;
    #1;
    chk("add_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("add_busy", {31'd0, busy_o}, 32'd0);
    start_i = 1'b0;

    // back-to-back
    do_mul(MUL_C, 32'd3, 32'd5,        5'd11, 32'd15, "b2b_first", d1);
    do_mul(MUL_C, 32'd0, 32'h12345678, 5'd12, 32'd0,  "b2b_second", d2);
    chk("b2b_spacing", d2 - d1, 32'd35);
    do_mul(MUL_C, 32'd7, 32'd6, 5'd13, 32'd42, "pre_rst", d1);
    go_idle();

    // reset mid-RUN
    @(negedge clk);
    start_i = 1'b1; alu_ctrl_i = MULHU_C; src_a_i = 32'hFFFFFFFF; src_b_i = 32'hFFFFFFFF; rd_i = 5'd14;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0; alu_ctrl_i = ADD_C;
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", {27'd0, rd_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_o === 1'b1 || busy_o === 1'b1) ndone++;
    end
    chk("midrst_quiet", ndone, 32'd0);
    do_mul(MUL_C, 32'd11, 32'd13, 5'd15, 32'd143, "after_rst", d3);
    go_idle();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
